// File: rtl/rtype_issue_ctrl.sv
// Multi-cycle R-type issue controller: accepts one instruction, decodes it, then
// drives the register-file read ports/ALU and writes the result back.
// Optional retire counter is enabled by defining RTYPE_RETIRE_CNT_EN.
module rtype_issue_ctrl #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InstrValid,
  input  logic [31:0] Instr,
  output logic        InstrReady,
  output logic [4:0]  RR1,
  output logic [4:0]  RR2,
  output logic [3:0]  Op,
  output logic [4:0]  ShiftCount,
  input  logic [31:0] ALUResult,
  output logic [4:0]  WR,
  output logic [31:0] WD,
  output logic        WE,
  output logic        Done,
  output logic        Illegal
`ifdef RTYPE_RETIRE_CNT_EN
  ,
  output logic [15:0] RetireCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  rr1_q, rr1_d;
  logic [4:0]  rr2_q, rr2_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  sc_q, sc_d;
  logic [4:0]  wr_q, wr_d;
  logic [31:0] wd_q, wd_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic [2:0]  wait_q, wait_d;
`ifdef RTYPE_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;
`endif

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        dec_ok, dec_shift;
  logic [3:0]  dec_op;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign funct  = instr_q[5:0];

  always_comb begin
    dec_ok    = 1'b1;
    dec_shift = 1'b0;
    dec_op    = '0;
    case (funct)
      6'h20:   dec_op = 4'b0010;
      6'h22:   dec_op = 4'b0110;
      6'h24:   dec_op = 4'b0000;
      6'h25:   dec_op = 4'b0001;
      6'h27:   dec_op = 4'b1100;
      6'h2A:   dec_op = 4'b0111;
      6'h00:   begin dec_op = 4'b1110; dec_shift = 1'b1; end
      6'h02:   begin dec_op = 4'b1101; dec_shift = 1'b1; end
      6'h03:   begin dec_op = 4'b1111; dec_shift = 1'b1; end
      default: dec_ok = 1'b0;
    endcase
    if (opcode != '0) dec_ok = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    rr1_d     = rr1_q;
    rr2_d     = rr2_q;
    op_d      = op_q;
    sc_d      = sc_q;
    wr_d      = wr_q;
    wd_d      = wd_q;
    wait_d    = wait_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef RTYPE_RETIRE_CNT_EN
    retire_cnt_d = retire_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (InstrValid) begin
          instr_d = Instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!dec_ok) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          // Shifts operate on ALU operand A, so rt is routed to both read ports.
          rr1_d   = dec_shift ? rt : rs;
          rr2_d   = rt;
          op_d    = dec_op;
          sc_d    = dec_shift ? shamt : '0;
          wait_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (wait_q == 3'(READ_WAIT - 1)) state_d = S_EXEC;
        else                              wait_d  = wait_q + 3'd1;
      end
      S_EXEC: begin
        wd_d    = ALUResult;
        wr_d    = rd;
        we_d    = (rd != '0);
        done_d  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
`ifdef RTYPE_RETIRE_CNT_EN
        retire_cnt_d = retire_cnt_q + 16'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      rr1_q     <= '0;
      rr2_q     <= '0;
      op_q      <= '0;
      sc_q      <= '0;
      wr_q      <= '0;
      wd_q      <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      wait_q    <= '0;
`ifdef RTYPE_RETIRE_CNT_EN
      retire_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      rr1_q     <= rr1_d;
      rr2_q     <= rr2_d;
      op_q      <= op_d;
      sc_q      <= sc_d;
      wr_q      <= wr_d;
      wd_q      <= wd_d;
      we_q      <= we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      wait_q    <= wait_d;
`ifdef RTYPE_RETIRE_CNT_EN
      retire_cnt_q <= retire_cnt_d;
`endif
    end
  end

  assign InstrReady = (state_q == S_IDLE);
  assign RR1        = rr1_q;
  assign RR2        = rr2_q;
  assign Op         = op_q;
  assign ShiftCount = sc_q;
  assign WR         = wr_q;
  assign WD         = wd_q;
  assign WE         = we_q;
  assign Done       = done_q;
  assign Illegal    = illegal_q;
`ifdef RTYPE_RETIRE_CNT_EN
  assign RetireCount = retire_cnt_q;
`endif

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// Directed bench for rtype_issue_ctrl with a register-file (reg[i]=i) and ALU model.
module tb_rtype_issue_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        InstrValid = 1'b0;
  logic [31:0] Instr = '0;
  logic        InstrReady;
  logic [4:0]  RR1, RR2, ShiftCount, WR;
  logic [3:0]  Op;
  logic [31:0] ALUResult, WD;
  logic        WE, Done, Illegal;
`ifdef RTYPE_RETIRE_CNT_EN
  logic [15:0] RetireCount;
`endif

  int vecs = 0;
  int errs = 0;

  logic [31:0] regs [32];

  rtype_issue_ctrl #(.READ_WAIT(1)) dut (
    .Clk(Clk), .Rst(Rst), .InstrValid(InstrValid), .Instr(Instr),
    .InstrReady(InstrReady), .RR1(RR1), .RR2(RR2), .Op(Op),
    .ShiftCount(ShiftCount), .ALUResult(ALUResult), .WR(WR), .WD(WD),
    .WE(WE), .Done(Done), .Illegal(Illegal)
`ifdef RTYPE_RETIRE_CNT_EN
    , .RetireCount(RetireCount)
`endif
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (WE) regs[WR] <= WD;

  always_comb begin
    logic [31:0] a, b;
    a = regs[RR1];
    b = regs[RR2];
    case (Op)
      4'b0010: ALUResult = a + b;
      4'b0110: ALUResult = a - b;
      4'b0000: ALUResult = a & b;
      4'b0001: ALUResult = a | b;
      4'b1100: ALUResult = ~(a | b);
      4'b0111: ALUResult = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1110: ALUResult = a << ShiftCount;
      4'b1101: ALUResult = a >> ShiftCount;
      4'b1111: ALUResult = $signed(a) >>> ShiftCount;
      default: ALUResult = '0;
    endcase
  end

  task automatic init_regs();
    for (int i = 0; i < 32; i++) regs[i] = i;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  // Returns one cycle after the accept edge (DECODE cycle).
  task automatic issue(input logic [31:0] w);
    int n = 0;
    while (InstrReady !== 1'b1 && n < 20) begin step(1); n++; end
    vecs++;
    if (InstrReady !== 1'b1) begin
      errs++; $display("FAIL ready_timeout got=%b exp=1", InstrReady);
    end
    Instr = w; InstrValid = 1'b1;
    step(1);
    InstrValid = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; #2;
    vecs++;
    if ({InstrReady, RR1, RR2, Op, ShiftCount, WR} !== {1'b1, 24'h0}) begin
      errs++; $display("FAIL reset_ctrl got=%b/%0d/%0d/%0d/%0d/%0d exp=1/0/0/0/0/0",
                       InstrReady, RR1, RR2, Op, ShiftCount, WR);
    end
    vecs++;
    if ({WD, WE, Done, Illegal} !== 35'h0) begin
      errs++; $display("FAIL reset_wb got=%h/%b/%b/%b exp=0/0/0/0", WD, WE, Done, Illegal);
    end
`ifdef RTYPE_RETIRE_CNT_EN
    vecs++;
    if (RetireCount !== 16'h0) begin errs++; $display("FAIL reset_cnt got=%h exp=0", RetireCount); end
`endif
    @(negedge Clk); Rst = 1'b0;
    step(1);
  endtask

  task automatic test_add();
    issue(32'h00672820);
    vecs++; if (InstrReady !== 1'b0) begin errs++; $display("FAIL add_busy got=%b exp=0", InstrReady); end
    step(1);
    vecs++;
    if (RR1 !== 5'd3 || RR2 !== 5'd7 || Op !== 4'b0010 || ShiftCount !== 5'd0) begin
      errs++; $display("FAIL add_read got=%0d/%0d/%b/%0d exp=3/7/0010/0", RR1, RR2, Op, ShiftCount);
    end
    step(1);
    vecs++; if (WE !== 1'b0 || Done !== 1'b0) begin errs++; $display("FAIL add_exec got=%b/%b exp=0/0", WE, Done); end
    step(1);
    vecs++;
    if (WE !== 1'b1 || WR !== 5'd5 || WD !== 32'd10 || Done !== 1'b1) begin
      errs++; $display("FAIL add_write got=%b/%0d/%0d/%b exp=1/5/10/1", WE, WR, WD, Done);
    end
    step(1);
    vecs++;
    if (WE !== 1'b0 || Done !== 1'b0 || InstrReady !== 1'b1 || regs[5] !== 32'd10 || RR1 !== 5'd3) begin
      errs++; $display("FAIL add_after got=%b/%b/%b/%0d/%0d exp=0/0/1/10/3", WE, Done, InstrReady, regs[5], RR1);
    end
  endtask

  task automatic test_sll();
    issue(32'h000220C0);
    step(1);
    vecs++;
    if (RR1 !== 5'd2 || RR2 !== 5'd2 || Op !== 4'b1110 || ShiftCount !== 5'd3) begin
      errs++; $display("FAIL sll_read got=%0d/%0d/%b/%0d exp=2/2/1110/3", RR1, RR2, Op, ShiftCount);
    end
    step(2);
    vecs++;
    if (WE !== 1'b1 || WR !== 5'd4 || WD !== 32'd16 || Done !== 1'b1) begin
      errs++; $display("FAIL sll_write got=%b/%0d/%0d/%b exp=1/4/16/1", WE, WR, WD, Done);
    end
    step(1);
  endtask

  task automatic test_rd0();
    issue(32'h00220020);
    step(3);
    vecs++;
    if (Done !== 1'b1 || WE !== 1'b0 || WR !== 5'd0 || WD !== 32'd3) begin
      errs++; $display("FAIL rd0_write got=%b/%b/%0d/%0d exp=1/0/0/3", Done, WE, WR, WD);
    end
    step(1);
    vecs++; if (regs[0] !== 32'd0) begin errs++; $display("FAIL rd0_reg got=%0d exp=0", regs[0]); end
  endtask

  task automatic test_illegal();
    logic [31:0] words [2];
    words[0] = 32'h8C220000;
    words[1] = 32'h00000001;
    for (int i = 0; i < 2; i++) begin
      issue(words[i]);
      vecs++;
      if (Illegal !== 1'b0 || InstrReady !== 1'b0) begin
        errs++; $display("FAIL ill%0d_decode got=%b/%b exp=0/0", i, Illegal, InstrReady);
      end
      step(1);
      vecs++;
      if (Illegal !== 1'b1 || InstrReady !== 1'b1 || WE !== 1'b0 || Done !== 1'b0) begin
        errs++; $display("FAIL ill%0d_pulse got=%b/%b/%b/%b exp=1/1/0/0", i, Illegal, InstrReady, WE, Done);
      end
    end
    issue(32'h00672820);
    vecs++; if (Illegal !== 1'b0) begin errs++; $display("FAIL ill_clear got=%b exp=0", Illegal); end
    step(3);
    vecs++;
    if (Done !== 1'b1 || WD !== 32'd10) begin
      errs++; $display("FAIL ill_next got=%b/%0d exp=1/10", Done, WD);
    end
    step(1);
  endtask

  task automatic test_reset_midop();
    int bad;
    init_regs();
    issue(32'h00672820);
    step(1);
    Rst = 1'b1; #1;
    vecs++;
    if (WE !== 1'b0 || InstrReady !== 1'b1 || RR1 !== 5'd0 || Op !== 4'b0000) begin
      errs++; $display("FAIL rst_read got=%b/%b/%0d/%b exp=0/1/0/0000", WE, InstrReady, RR1, Op);
    end
    step(1);
    Rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (Done !== 1'b0 || WE !== 1'b0) bad++;
      step(1);
    end
    vecs++;
    if (bad != 0 || regs[5] !== 32'd5) begin
      errs++; $display("FAIL rst_discard got=%0d/%0d exp=0/5", bad, regs[5]);
    end
    // Abort in the WRITE cycle: WE must fall at once and the write must not land.
    issue(32'h00672820);
    step(3);
    #2 Rst = 1'b1; #1;
    vecs++; if (WE !== 1'b0 || Done !== 1'b0) begin errs++; $display("FAIL rst_write got=%b/%b exp=0/0", WE, Done); end
    @(negedge Clk); Rst = 1'b0;
    step(2);
    vecs++; if (regs[5] !== 32'd5) begin errs++; $display("FAIL rst_noreg got=%0d exp=5", regs[5]); end
    issue(32'h00672820);
    step(3);
    vecs++;
    if (Done !== 1'b1 || WE !== 1'b1 || WD !== 32'd10) begin
      errs++; $display("FAIL rst_retry got=%b/%b/%0d exp=1/1/10", Done, WE, WD);
    end
    step(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [7];
    logic [4:0]  e1 [7], e2 [7], esc [7], ewr [7];
    logic [3:0]  eop [7];
    logic [31:0] ewd [7];
    w[0] = 32'h00E33022; e1[0] = 7;  e2[0] = 3;  eop[0] = 4'b0110; esc[0] = 0; ewr[0] = 6;  ewd[0] = 32'd4;
    w[1] = 32'h000C5082; e1[1] = 12; e2[1] = 12; eop[1] = 4'b1101; esc[1] = 2; ewr[1] = 10; ewd[1] = 32'd3;
    w[2] = 32'h000D5843; e1[2] = 13; e2[2] = 13; eop[2] = 4'b1111; esc[2] = 1; ewr[2] = 11; ewd[2] = 32'd6;
    w[3] = 32'h02117825; e1[3] = 16; e2[3] = 17; eop[3] = 4'b0001; esc[3] = 0; ewr[3] = 15; ewd[3] = 32'd17;
    w[4] = 32'h01A77024; e1[4] = 13; e2[4] = 7;  eop[4] = 4'b0000; esc[4] = 0; ewr[4] = 14; ewd[4] = 32'd5;
    w[5] = 32'h0067402A; e1[5] = 3;  e2[5] = 7;  eop[5] = 4'b0111; esc[5] = 0; ewr[5] = 8;  ewd[5] = 32'd1;
    w[6] = 32'h00224827; e1[6] = 1;  e2[6] = 2;  eop[6] = 4'b1100; esc[6] = 0; ewr[6] = 9;  ewd[6] = 32'hFFFFFFFC;
    init_regs();
    for (int i = 0; i < 7; i++) begin
      vecs++;
      if (InstrReady !== 1'b1) begin errs++; $display("FAIL b2b%0d_ready got=%b exp=1", i, InstrReady); end
      issue(w[i]);
      step(1);
      vecs++;
      if (RR1 !== e1[i] || RR2 !== e2[i] || Op !== eop[i] || ShiftCount !== esc[i]) begin
        errs++; $display("FAIL b2b%0d_read got=%0d/%0d/%b/%0d exp=%0d/%0d/%b/%0d",
                         i, RR1, RR2, Op, ShiftCount, e1[i], e2[i], eop[i], esc[i]);
      end
      step(2);
      vecs++;
      if (WE !== 1'b1 || Done !== 1'b1 || WR !== ewr[i] || WD !== ewd[i]) begin
        errs++; $display("FAIL b2b%0d_write got=%b/%b/%0d/%h exp=1/1/%0d/%h",
                         i, WE, Done, WR, WD, ewr[i], ewd[i]);
      end
      step(1);
    end
  endtask

`ifdef RTYPE_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    Rst = 1'b1; #1;
    @(negedge Clk); Rst = 1'b0;
    step(1);
    issue(32'h00672820); step(4);
    issue(32'h8C220000); step(1);
    issue(32'h000220C0); step(4);
    issue(32'h00220020); step(4);
    vecs++; if (RetireCount !== 16'd3) begin errs++; $display("FAIL cnt_three got=%0d exp=3", RetireCount); end
    dut.retire_cnt_q <= 16'hFFFF;
    #1;
    issue(32'h00672820); step(4);
    vecs++; if (RetireCount !== 16'h0000) begin errs++; $display("FAIL cnt_wrap got=%h exp=0000", RetireCount); end
  endtask
`endif

  initial begin
    init_regs();
    test_reset();
    test_add();
    test_sll();
    test_rd0();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
`ifdef RTYPE_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rtype_issue_ctrl.md
# rtype_issue_ctrl

Multi-cycle issue controller for R-type instructions. It accepts one instruction word over a valid/ready handshake and decodes it. It then drives the register-file read ports and the ALU opcode and shift count, captures the ALU result, and writes the result back through the register-file write port. It is the initiator side of the register-file/ALU datapath and replaces testbench-driven stimulus of RR1/RR2/WR/WE/Op.

## Interface
- READ_WAIT, 1, cycles spent in READ for register-file/ALU settling; legal range 1–7.

- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active-high.
- InstrValid  in  1  instruction word present.
- Instr  in  32  MIPS R-type word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- InstrReady  out  1  controller can accept an instruction.
- RR1  out  5  register-file read address 1.
- RR2  out  5  register-file read address 2.
- Op  out  4  ALU operation code.
- ShiftCount  out  5  ALU shift amount.
- ALUResult  in  32  ALU result (combinational from RR1/RR2/Op/ShiftCount).
- WR  out  5  register-file write address.
- WD  out  32  register-file write data (captured ALUResult).
- WE  out  1  register-file write enable, registered.
- Done  out  1  one-cycle pulse, instruction retired.
- Illegal  out  1  one-cycle pulse, instruction rejected.
- RetireCount  out  16  retired-instruction counter (only with RTYPE_RETIRE_CNT_EN).

## Operation
- States: IDLE, DECODE, READ, EXEC, WRITE.
- IDLE: InstrReady=1. If InstrValid=1 at a rising edge, latch Instr and go to DECODE. Otherwise stay in IDLE.
- DECODE: decode funct. If opcode≠0 or funct is unsupported, pulse Illegal and go to IDLE with no write. Otherwise drive the read addresses, Op and ShiftCount, then go to READ.
- funct→Op mapping:
  - 0x20 add → 0010
  - 0x22 sub → 0110
  - 0x24 and → 0000
  - 0x25 or → 0001
  - 0x27 nor → 1100
  - 0x2A slt → 0111
  - 0x00 sll → 1110
  - 0x02 srl → 1101
  - 0x03 sra → 1111
- Non-shift ops: RR1=rs, RR2=rt, ShiftCount=0.
- Shift ops: RR1=rt (the ALU shifts operand A), RR2=rt, ShiftCount=shamt.
- READ: hold RR1/RR2/Op/ShiftCount for READ_WAIT cycles, then go to EXEC.
- EXEC: capture ALUResult into WD at the exit edge, then go to WRITE.
- WRITE: WR=rd. WE=1 for exactly this cycle unless rd=0, in which case WE stays 0. Done=1 in this cycle. Next state is IDLE.
- RR1, RR2, Op, ShiftCount, WR and WD hold their last values outside their active states. No outputs are high-Z.

## Timing
- Reset values: state=IDLE, InstrReady=1, RR1=RR2=WR=0, Op=0000, ShiftCount=0, WD=0, WE=0, Done=0, Illegal=0, RetireCount=0.
- Rst clears every register asynchronously. This includes mid-instruction: WE drops immediately and the in-flight instruction is discarded with no write and no Done. The first accept is possible at the first rising edge after Rst deasserts.
- Legal instruction, accept edge = edge 0: DECODE runs in cycle 1, READ in cycles 2…1+READ_WAIT, EXEC in cycle 2+READ_WAIT, WRITE in cycle 3+READ_WAIT.
- Next accept is possible at the edge ending WRITE+1 (the IDLE cycle). Throughput is one instruction per 4+READ_WAIT cycles.
- Illegal instruction: Illegal is high in cycle 2 (the IDLE cycle after DECODE). The next accept is at the end of cycle 2.
- InstrValid while InstrReady=0 is ignored. The source must hold Instr and InstrValid until the accept edge.
- Done and Illegal are never high together.

## Configuration
- RTYPE_RETIRE_CNT_EN defined: RetireCount increments by 1 at the end of every WRITE cycle, including rd=0 cases. It wraps 0xFFFF→0x0000, resets to 0, and does not count Illegal instructions.
- RTYPE_RETIRE_CNT_EN undefined: the RetireCount port and its logic are absent. All other behaviour is identical.

## Test plan
Bench setup: READ_WAIT=1. The register-file model is initialised with reg[i]=i and the ALU model uses the opcodes above.
- Reset: Rst pulse → all outputs at their reset values, InstrReady=1.
- add: Instr=0x00672820 (add $5,$3,$7) → RR1=3, RR2=7, Op=0010. WE=1, WR=5, WD=10 in cycle 4. Done pulses in the same cycle. reg[5]=10 afterwards.
- sll: Instr=0x000220C0 (sll $4,$2,3) → RR1=2, ShiftCount=3, Op=1110, WR=4, WD=16.
- rd=0 and illegal:
  - Instr=0x00220020 (add $0,$1,$2) → Done pulses, WE stays 0.
  - Instr=0x8C220000 (opcode 0x23) → Illegal pulses in cycle 2, WE never asserts, InstrReady=1 in cycle 2.
- Reset mid-op: assert Rst during READ of 0x00672820 → WE=0 immediately and reg[5] is unchanged. After release, the same instruction completes with WD=10.
- With RTYPE_RETIRE_CNT_EN: issue three legal instructions and one illegal one → RetireCount=3. Preload the counter at 0xFFFF and retire one instruction → RetireCount=0x0000.
